// File: rtl/rgu_pixel_scheduler_pkg.sv
// Shared definitions for the RGU pixel scheduler: FSM encoding, default register
// addresses and the host-address bit that separates register file from instruction memory.
package rgu_pixel_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_Y = 3'd2,
        ST_RUN    = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FINISH = 3'd5
    } sched_state_t;

    localparam logic [7:0] REG_PIXEL_X_DEFAULT = 8'd2;
    localparam logic [7:0] REG_PIXEL_Y_DEFAULT = 8'd3;

    // Host address bit that selects instruction memory on the RGU; 0 means register file.
    localparam int RGU_UART_ADDR_INSN = 5;

    function automatic logic [7:0] regfile_addr(input logic [7:0] reg_idx);
        logic [7:0] a;
        a = reg_idx;
        a[RGU_UART_ADDR_INSN] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/rgu_raster_counter.sv
// Raster-order X/Y pixel counter: latches the frame resolution, steps X then Y,
// and flags the last pixel so the scheduler knows when the frame is complete.
module rgu_raster_counter #(
    parameter int COORD_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [COORD_W-1:0] res_x,
    input  logic [COORD_W-1:0] res_y,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [COORD_W-1:0] res_x_q;
    logic [COORD_W-1:0] res_y_q;
    logic               x_end;
    logic               y_end;

    assign x_end = (x == res_x_q - COORD_W'(1));
    assign y_end = (y == res_y_q - COORD_W'(1));
    assign last  = x_end && y_end;

    // Advancing past the last pixel is suppressed so counters stay inside the frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_x_q <= '0;
            res_y_q <= '0;
            x       <= '0;
            y       <= '0;
        end else if (load) begin
            res_x_q <= res_x;
            res_y_q <= res_y;
            x       <= '0;
            y       <= '0;
        end else if (advance && !last) begin
            if (x_end) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/rgu_pixel_scheduler.sv
// Frame sequencer for the ray generation unit: loads pixel X/Y through the host port,
// runs the RGU until a pixel's pushes are seen, then steps raster order to frame end.
module rgu_pixel_scheduler
    import rgu_pixel_scheduler_pkg::*;
#(
    parameter int         COORD_W          = 16,
    parameter int         SCALE            = 16,
    parameter logic [7:0] REG_PIXEL_X      = REG_PIXEL_X_DEFAULT,
    parameter logic [7:0] REG_PIXEL_Y      = REG_PIXEL_Y_DEFAULT,
    parameter int         PUSHES_PER_PIXEL = 3,
    parameter int         WDOG_CYCLES      = 255
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [COORD_W-1:0] iResX,
    input  logic [COORD_W-1:0] iResY,
    input  logic               iFifoAlmostFull,
    input  logic               iRguFifoPush,
    output logic               oRguEnable,
    output logic               oRguSelected,
    output logic               oRguWrite,
    output logic [7:0]         oRguAddr,
    output logic [63:0]        oRguData,
    output logic [COORD_W-1:0] oPixelX,
    output logic [COORD_W-1:0] oPixelY,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output sched_state_t       oState
);

    localparam int PUSH_W = $clog2(PUSHES_PER_PIXEL + 1);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [PUSH_W-1:0] PUSH_LAST = PUSH_W'(PUSHES_PER_PIXEL - 1);
    localparam logic [PUSH_W-1:0] PUSH_MAX  = PUSH_W'(PUSHES_PER_PIXEL);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    sched_state_t       state_q;
    logic [PUSH_W-1:0]  push_cnt;
    logic [WDOG_W-1:0]  wdog_cnt;
    logic               done_q;
    logic               error_q;
    logic               start_frame;
    logic               res_zero;
    logic               last_pixel;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;

    assign start_frame = (state_q == ST_IDLE) && iStart && !iAbort;
    assign res_zero    = (iResX == '0) || (iResY == '0);

    rgu_raster_counter #(
        .COORD_W (COORD_W)
    ) u_raster (
        .clock   (iClock),
        .reset   (iReset),
        .load    (start_frame),
        .advance ((state_q == ST_NEXT) && !iAbort),
        .res_x   (iResX),
        .res_y   (iResY),
        .x       (pixel_x),
        .y       (pixel_y),
        .last    (last_pixel)
    );

    // Host port and run enable decode straight from the state register, so they are
    // mutually exclusive by construction; enable stalls combinationally on almost-full.
    always_comb begin
        oRguSelected = 1'b0;
        oRguWrite    = 1'b0;
        oRguAddr     = '0;
        oRguData     = '0;
        oRguEnable   = (state_q == ST_RUN) && !iFifoAlmostFull;
        case (state_q)
            ST_LOAD_X: begin
                oRguSelected = 1'b1;
                oRguWrite    = 1'b1;
                oRguAddr     = regfile_addr(REG_PIXEL_X);
                oRguData     = {{(64 - COORD_W){1'b0}}, pixel_x} << SCALE;
            end
            ST_LOAD_Y: begin
                oRguSelected = 1'b1;
                oRguWrite    = 1'b1;
                oRguAddr     = regfile_addr(REG_PIXEL_Y);
                oRguData     = {{(64 - COORD_W){1'b0}}, pixel_y} << SCALE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            push_cnt <= '0;
            wdog_cnt <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (iAbort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (iStart) begin
                            error_q <= 1'b0;
                            state_q <= res_zero ? ST_FINISH : ST_LOAD_X;
                        end
                    end
                    ST_LOAD_X: state_q <= ST_LOAD_Y;
                    ST_LOAD_Y: begin
                        push_cnt <= '0;
                        wdog_cnt <= '0;
                        state_q  <= ST_RUN;
                    end
                    ST_RUN: begin
                        // Pushes count even while stalled: they were launched a cycle earlier.
                        if (iRguFifoPush && push_cnt != PUSH_MAX)
                            push_cnt <= push_cnt + 1'b1;
                        if (oRguEnable)
                            wdog_cnt <= wdog_cnt + 1'b1;
                        if (iRguFifoPush && push_cnt == PUSH_LAST) begin
                            state_q <= ST_NEXT;
                        end else if (oRguEnable && wdog_cnt == WDOG_LAST) begin
                            error_q <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                    ST_NEXT:   state_q <= last_pixel ? ST_FINISH : ST_LOAD_X;
                    ST_FINISH: begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign oPixelX = pixel_x;
    assign oPixelY = pixel_y;
    assign oBusy   = (state_q != ST_IDLE);
    assign oDone   = done_q;
    assign oError  = error_q;
    assign oState  = state_q;

endmodule

// File: tb/tb_rgu_pixel_scheduler.sv
// Self-checking bench for rgu_pixel_scheduler: an RGU push model, randomized frames and
// backpressure, and a raster-order reference of the expected host writes.
module tb_rgu_pixel_scheduler;
    import rgu_pixel_scheduler_pkg::*;

    localparam int PPP  = 3;
    localparam int WDOG = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start, abort_in;
    logic [15:0]  res_x, res_y;
    logic         af, af_force, af_rand, bp_rand_en;
    logic         rgu_push;
    logic         rgu_enable, rgu_sel, rgu_write, busy, done, error;
    logic [7:0]   rgu_addr;
    logic [63:0]  rgu_data;
    logic [15:0]  pixel_x, pixel_y;
    sched_state_t dbg_state;

    always #5 clk = ~clk;
    assign af = af_force | af_rand;

    rgu_pixel_scheduler dut (
        .iClock          (clk),
        .iReset          (rst),
        .iStart          (start),
        .iAbort          (abort_in),
        .iResX           (res_x),
        .iResY           (res_y),
        .iFifoAlmostFull (af),
        .iRguFifoPush    (rgu_push),
        .oRguEnable      (rgu_enable),
        .oRguSelected    (rgu_sel),
        .oRguWrite       (rgu_write),
        .oRguAddr        (rgu_addr),
        .oRguData        (rgu_data),
        .oPixelX         (pixel_x),
        .oPixelY         (pixel_y),
        .oBusy           (busy),
        .oDone           (done),
        .oError          (error),
        .oState          (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RGU model: one push per enabled cycle (optionally random), registered one stage
    // after enable, at most PPP pushes per pixel, re-armed by the Y register write.
    logic push_gate, push_rand;
    int   pushes_left;
    always @(posedge clk) begin
        if (rst) begin
            rgu_push    <= 1'b0;
            pushes_left <= 0;
        end else begin
            rgu_push <= 1'b0;
            if (rgu_write && rgu_addr == 8'd3)
                pushes_left <= PPP;
            else if (rgu_enable && push_gate && pushes_left > 0 &&
                     (!push_rand || $urandom_range(0, 1) == 1)) begin
                rgu_push    <= 1'b1;
                pushes_left <= pushes_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        af_rand = bp_rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    // Monitor: samples on the falling edge and logs everything per frame.
    int          cyc = 0;
    logic [71:0] wr_q[$];
    int          wr_cyc_q[$];
    int          first_en_cyc = -1;
    int          done_cnt = 0, done_cyc = -1, push_seen = 0, en_cycles = 0;
    int          overlap_bad = 0, bp_bad = 0;
    always @(negedge clk) begin
        cyc++;
        if (rgu_write) begin
            wr_q.push_back({rgu_addr, rgu_data});
            wr_cyc_q.push_back(cyc);
        end
        if (rgu_enable) begin
            en_cycles++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
        end
        if (rgu_enable && af) bp_bad++;
        if (rgu_enable && (rgu_write || rgu_sel)) overlap_bad++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rgu_push) push_seen++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int start_cyc;

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc_q.delete();
        first_en_cyc = -1;
        done_cnt = 0; done_cyc = -1; push_seen = 0; en_cycles = 0;
        overlap_bad = 0; bp_bad = 0;
    endtask

    task automatic start_frame(input int w, input int h);
        res_x = 16'(w);
        res_y = 16'(h);
        clear_logs();
        start_cyc = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt == 0) $display("FAIL wait_done: no oDone within %0d cycles", budget);
        tick(2);
    endtask

    // Reference: one X then one Y register write per pixel, raster order, coord << 16.
    task automatic check_writes(input string tag, input int w, input int h);
        logic [71:0] exp_q[$];
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                exp_q.push_back({8'd2, 64'(x) << 16});
                exp_q.push_back({8'd3, 64'(y) << 16});
            end
        check($sformatf("%s_nwrites", tag), 72'(wr_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    endtask

    task automatic check_frame(input string tag, input int w, input int h);
        check_writes(tag, w, h);
        check({tag, "_done"}, 72'(done_cnt), 72'(1));
        check({tag, "_pushes"}, 72'(push_seen), 72'(w * h * PPP));
        check({tag, "_overlap"}, 72'(overlap_bad), 72'(0));
        check({tag, "_bp"}, 72'(bp_bad), 72'(0));
        check({tag, "_err"}, 72'(error), 72'(0));
        check({tag, "_idle"}, 72'(busy), 72'(0));
    endtask

    initial begin
        int n, w, h, stall_bad;
        start = 0; abort_in = 0; res_x = 0; res_y = 0;
        af_force = 0; bp_rand_en = 0; push_gate = 1; push_rand = 0;

        // Reset state
        tick(3);
        check("rst_ctrl", {busy, done, error, rgu_enable, rgu_sel, rgu_write}, 72'(0));
        check("rst_host", {rgu_addr, rgu_data}, 72'(0));
        check("rst_pix", {pixel_x, pixel_y}, 72'(0));
        check("rst_state", 72'(dbg_state), 72'(ST_IDLE));
        rst = 0;
        tick(2);

        // 2x2 frame, no backpressure, plus start timing
        start_frame(2, 2);
        wait_done(400);
        check_frame("f2x2", 2, 2);
        check("t_wr_x", 72'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] - start_cyc : -1), 72'(1));
        check("t_wr_y", 72'(wr_cyc_q.size() > 1 ? wr_cyc_q[1] - start_cyc : -1), 72'(2));
        check("t_en", 72'(first_en_cyc - start_cyc), 72'(3));

        // Zero resolution: immediate done, no host activity
        start_frame(0, 5);
        tick(4);
        check("z_done_cyc", 72'(done_cyc - start_cyc), 72'(2));
        check("z_done_cnt", 72'(done_cnt), 72'(1));
        check("z_writes", 72'(wr_q.size()), 72'(0));
        check("z_en", 72'(first_en_cyc), 72'(-1));

        // 10-cycle almost-full stall with a push in flight
        push_gate = 0;
        start_frame(1, 1);
        n = 0;
        while (!rgu_enable && n < 20) begin tick(1); n++; end
        check("st_en_seen", 72'(rgu_enable), 72'(1));
        tick(5);
        push_gate = 1;
        tick(1);
        af_force = 1;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rgu_enable !== 1'b0) stall_bad++;
            tick(1);
        end
        af_force = 0;
        #1;
        check("st_en_low", 72'(stall_bad), 72'(0));
        check("st_en_back", 72'(rgu_enable), 72'(1));
        wait_done(300);
        check_frame("st", 1, 1);

        // Watchdog: RGU never pushes
        push_gate = 0;
        start_frame(1, 1);
        wait_done(600);
        check("wd_en_cycles", 72'(en_cycles), 72'(WDOG));
        check("wd_err", 72'(error), 72'(1));
        check("wd_done", 72'(done_cnt), 72'(1));
        check("wd_idle", 72'(busy), 72'(0));
        push_gate = 1;
        start_frame(1, 1);
        check("wd_err_clr", 72'(error), 72'(0));
        wait_done(300);
        check_frame("wd_next", 1, 1);

        // Abort during RUN of pixel (3,1) in a 4x4 frame
        push_rand = 1;
        start_frame(4, 4);
        n = 0;
        while (wr_q.size() < 16 && n < 2000) begin tick(1); n++; end
        n = 0;
        while (!rgu_enable && n < 50) begin tick(1); n++; end
        check("ab_px_x", wr_q.size() > 14 ? wr_q[14] : '1, {8'd2, 64'(3) << 16});
        check("ab_px_y", wr_q.size() > 15 ? wr_q[15] : '1, {8'd3, 64'(1) << 16});
        check("ab_in_run", 72'(rgu_enable), 72'(1));
        abort_in = 1;
        tick(1);
        abort_in = 0;
        check("ab_idle", {busy, rgu_enable, rgu_write}, 72'(0));
        tick(5);
        check("ab_no_done", 72'(done_cnt), 72'(0));
        start_frame(2, 2);
        wait_done(600);
        check_frame("ab_restart", 2, 2);

        // Randomized frames with random backpressure and push timing
        bp_rand_en = 1;
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 3);
            start_frame(w, h);
            wait_done(3000);
            check_frame($sformatf("rnd%0d_%0dx%0d", k, w, h), w, h);
        end
        bp_rand_en = 0;
        push_rand = 0;
        tick(2);

        // Reset mid-frame
        start_frame(3, 3);
        tick(4);
        rst = 1;
        tick(1);
        check("mr_idle", {busy, rgu_enable, rgu_write, rgu_sel}, 72'(0));
        rst = 0;
        tick(2);
        start_frame(1, 2);
        wait_done(300);
        check_frame("mr_after", 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
